// File: rtl/vending_machine.sv
// vending_machine -- single-clock vending controller.
//
// Adds up coin credit, or checks an external credit balance, against a 7-slot
// price table. When the selected item can be paid for, it is dispensed. Change
// is returned as counts of quarters, dimes and nickels.
//
// Optional feature macro: VEND_CREDIT_EN
//   defined   : credit path present (paymentMethod, creditBalance, CVEND/HOLD)
//   undefined : coin-only operation; paymentMethod and creditBalance ignored
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   index[2:0]     selected slot 0..6, 7 = no selection
//   paymentMethod  0 = coins, 1 = external credit
//   creditBalance  external credit in cents
//   nickel/dime/quarter  coin-acceptor levels, one coin per rising edge
//   cost[20:0]     price codes, slot k = cost[3k+2:3k]; 0 = out of stock,
//                  n = n*50 cents
//   cancel         refund the coin balance
//   dispensed      one-cycle vend pulse
//   quart/dim/nick change coin counts; non-zero only in the change cycle
//   pen            pennies; always 0 because balances are multiples of 5 c
module vending_machine (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  index,
  input  logic        paymentMethod,
  input  logic [8:0]  creditBalance,
  input  logic        nickel,
  input  logic        dime,
  input  logic        quarter,
  input  logic [20:0] cost,
  input  logic        cancel,
  output logic        dispensed,
  output logic [3:0]  quart,
  output logic [2:0]  dim,
  output logic [2:0]  nick,
  output logic [2:0]  pen
);

`ifdef VEND_CREDIT_EN
  typedef enum logic [2:0] {S_IDLE, S_VEND, S_RETURN, S_CVEND, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_VEND, S_RETURN} state_t;
`endif

  localparam logic [8:0] BAL_CAP = 9'd395;

  state_t      state;
  logic [8:0]  balance;
  logic        nickel_prev, dime_prev, quarter_prev;

  logic        nickel_edge, dime_edge, quarter_edge;
  logic [8:0]  balance_acc;
  logic [2:0]  code;
  logic [8:0]  price;
  logic        vendable;
  logic [9:0]  vend_chg;
  logic [9:0]  ret_chg;
  logic        credit_mode;

`ifdef VEND_CREDIT_EN
  assign credit_mode = paymentMethod;
`else
  logic unused_credit;
  assign unused_credit = ^{paymentMethod, creditBalance};
  assign credit_mode   = 1'b0;
`endif

  // Greedy split of a cents value into {quarters, dimes, nickels}. The 395 c
  // cap keeps this within 15 quarters + 2 dimes + 0 nickels.
  function automatic logic [9:0] greedy(input logic [8:0] v);
    logic [8:0] r;
    logic [3:0] q;
    logic [2:0] d;
    logic [2:0] n;
    q = 4'(v / 9'd25);
    r = v % 9'd25;
    d = 3'(r / 9'd10);
    n = 3'((r % 9'd10) / 9'd5);
    return {q, d, n};
  endfunction

  assign nickel_edge  = nickel  & ~nickel_prev;
  assign dime_edge    = dime    & ~dime_prev;
  assign quarter_edge = quarter & ~quarter_prev;

  // Coins in the same cycle are added one at a time. This way a single coin
  // that would pass the cap is dropped, and the others are still counted.
  always_comb begin
    balance_acc = balance;
    if (quarter_edge && (balance_acc + 9'd25) <= BAL_CAP)
      balance_acc = balance_acc + 9'd25;
    if (dime_edge && (balance_acc + 9'd10) <= BAL_CAP)
      balance_acc = balance_acc + 9'd10;
    if (nickel_edge && (balance_acc + 9'd5) <= BAL_CAP)
      balance_acc = balance_acc + 9'd5;
  end

  // Price lookup. Index 7 matches no slot and reads as out of stock.
  always_comb begin
    code = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      if (index == k[2:0])
        code = cost[3*k +: 3];
    end
  end

  assign price    = {6'b0, code} * 9'd50;
  assign vendable = (index != 3'd7) && (code != 3'd0);
  assign vend_chg = greedy(balance - price);
  assign ret_chg  = greedy(balance);
  assign pen      = '0;

  // Outputs are registered when a 1-cycle state is entered. They are visible
  // for exactly the cycle spent in VEND/RETURN/CVEND and cleared on leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      balance      <= '0;
      nickel_prev  <= 1'b0;
      dime_prev    <= 1'b0;
      quarter_prev <= 1'b0;
      dispensed    <= 1'b0;
      quart        <= '0;
      dim          <= '0;
      nick         <= '0;
    end else begin
      nickel_prev  <= nickel;
      dime_prev    <= dime;
      quarter_prev <= quarter;
      dispensed    <= 1'b0;
      quart        <= '0;
      dim          <= '0;
      nick         <= '0;
      case (state)
        S_IDLE: begin
          if (cancel) begin
            state              <= S_RETURN;
            {quart, dim, nick} <= ret_chg;
            balance            <= '0;
          end else if (credit_mode) begin
            // Coins are ignored in credit mode. The coin balance is kept so
            // that a later cancel can refund it.
`ifdef VEND_CREDIT_EN
            if (vendable && creditBalance >= price) begin
              state     <= S_CVEND;
              dispensed <= 1'b1;
            end
`endif
          end else if (vendable && balance >= price) begin
            state              <= S_VEND;
            dispensed          <= 1'b1;
            {quart, dim, nick} <= vend_chg;
            balance            <= '0;
          end else begin
            balance <= balance_acc;
          end
        end
        S_VEND:   state <= S_IDLE;
        S_RETURN: state <= S_IDLE;
`ifdef VEND_CREDIT_EN
        S_CVEND:  state <= S_HOLD;
        S_HOLD:   if (!paymentMethod) state <= S_IDLE;
`endif
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  index;
  logic        paymentMethod;
  logic [8:0]  creditBalance;
  logic        nickel, dime, quarter;
  logic [20:0] cost;
  logic        cancel;
  logic        dispensed;
  logic [3:0]  quart;
  logic [2:0]  dim, nick, pen;

  int checks = 0;
  int errors = 0;
  int disp_count = 0;
  int base;

  always #5 clk = ~clk;

  vending_machine dut (
    .clk(clk), .rst(rst), .index(index), .paymentMethod(paymentMethod),
    .creditBalance(creditBalance), .nickel(nickel), .dime(dime),
    .quarter(quarter), .cost(cost), .cancel(cancel), .dispensed(dispensed),
    .quart(quart), .dim(dim), .nick(nick), .pen(pen)
  );

  // Pulse counter, sampled 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (dispensed === 1'b1) disp_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // kind: 0 nickel, 1 dime, 2 quarter. One cycle high, one cycle low.
  task automatic coin(input int kind);
    @(negedge clk);
    if (kind == 0) nickel = 1'b1; else if (kind == 1) dime = 1'b1; else quarter = 1'b1;
    @(negedge clk);
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
  endtask

  task automatic do_cancel();
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic d, input int q, input int dm, input int n);
    check({tag, "_disp"}, {31'b0, dispensed}, {31'b0, d});
    check({tag, "_quart"}, {28'b0, quart}, q);
    check({tag, "_dim"}, {29'b0, dim}, dm);
    check({tag, "_nick"}, {29'b0, nick}, n);
  endtask

  initial begin
    rst = 1'b1; index = 3'd7; paymentMethod = 1'b0; creditBalance = '0;
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
    // slots 6..0: codes 3,2,4,2,0,0,0
    cost = {3'd3, 3'd2, 3'd4, 3'd2, 3'd0, 3'd0, 3'd0};
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 0, 0, 0);
    check("reset_pen", {29'b0, pen}, 0);
    rst = 1'b0;

    // 1: index 5 (100 c), four quarters, exact change
    index = 3'd5;
    repeat (3) coin(2);
    coin(2);
    check_outs("t1_pre", 1'b0, 0, 0, 0);
    @(negedge clk);
    check_outs("t1_vend", 1'b1, 0, 0, 0);
    @(negedge clk);
    check("t1_post_disp", {31'b0, dispensed}, 0);
    check("t1_pulses", disp_count, 1);

    // 2: index 3 (100 c), 95 c then a quarter -> 20 c change
    index = 3'd3;
    repeat (3) coin(2);
    repeat (2) coin(1);
    check("t2_no_vend_95", disp_count, 1);
    coin(2);
    @(negedge clk);
    check_outs("t2_vend", 1'b1, 0, 2, 0);
    @(negedge clk);

    // 3: index 6 (150 c), 55 c then cancel
    index = 3'd6;
    base = disp_count;
    repeat (2) coin(2);
    coin(0);
    do_cancel();
    check_outs("t3_ret", 1'b0, 2, 0, 1);
    @(negedge clk);
    check_outs("t3_after", 1'b0, 0, 0, 0);
    // the next purchase must start from 0: index 5 still needs 4 quarters
    index = 3'd5;
    repeat (3) coin(2);
    check("t3_fresh_75", disp_count, base);
    coin(2);
    @(negedge clk);
    check_outs("t3_fresh_vend", 1'b1, 0, 0, 0);
    @(negedge clk);

    // 4: out-of-stock slot, 16 quarters, cap drops the last one
    index = 3'd0;
    base = disp_count;
    repeat (16) coin(2);
    check("t4_no_vend", disp_count, base);
    do_cancel();
    check_outs("t4_ret", 1'b0, 15, 0, 0);
    @(negedge clk);

    // invalid selection (7): a nickel and a dime accumulate, refund 15 c
    index = 3'd7;
    coin(0);
    coin(1);
    do_cancel();
    check_outs("t4b_ret", 1'b0, 0, 1, 1);
    check("t4b_no_vend", disp_count, base);
    @(negedge clk);

`ifdef VEND_CREDIT_EN
    // 5: credit vend, hold, re-arm
    index = 3'd4;
    base = disp_count;
    @(negedge clk);
    creditBalance = 9'd200;
    paymentMethod = 1'b1;
    @(negedge clk);
    check_outs("t5_cvend", 1'b1, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("t5_hold_one", disp_count, base + 1);
    paymentMethod = 1'b0;
    repeat (2) @(negedge clk);
    paymentMethod = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_revend", disp_count, base + 2);
    paymentMethod = 1'b0;
    creditBalance = '0;
    repeat (3) @(negedge clk);
`endif

    // 6: reset wipes a partial balance
    index = 3'd5;
    base = disp_count;
    repeat (3) coin(2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outs("t6_rst", 1'b0, 0, 0, 0);
    coin(2);
    repeat (2) @(negedge clk);
    check("t6_no_vend", disp_count, base);
    do_cancel();
    check_outs("t6_ret", 1'b0, 1, 0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
